uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
Serial transmitter for the UART link. It accepts one parallel byte per Data_Valid pulse and sends it LSB-first on TX_OUT as one frame: start bit, 8 data bits, optional parity bit, stop bit. Each bit lasts Prescale clock cycles. It contains the control FSM, a bit-period counter, a bit counter, a serializer, a parity generator and the output mux, and it drives the line idle-high between frames.

Parameters:
DATA_WIDTH, 8, width of the parallel data word and the number of data bits per frame.

Ports:
CLK  input  1  system clock; all state changes on the rising edge.
RST  input  1  synchronous, active-low reset, sampled on the rising edge of CLK.
P_DATA  input  DATA_WIDTH  parallel byte to send; sampled only on acceptance.
Data_Valid  input  1  request to send P_DATA; one-cycle pulse or level.
PAR_EN  input  1  1 = insert parity bit; sampled on acceptance.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
Prescale  input  6  bit period in CLK cycles; sampled on acceptance; 0 is treated as 1.
TX_OUT  output  1  serial line, registered; idle level is 1.
Busy  output  1  registered; high while a frame is in progress.

Behaviour:
- Reset (RST=0 at a rising edge): state=IDLE, TX_OUT=1, Busy=0, all counters and shadow registers cleared. Reset in the middle of a frame aborts the frame; the line is high after that same edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at an edge, the block latches P_DATA, PAR_EN, PAR_TYP and Prescale (0 becomes 1) into shadow registers. After that edge the state is START, TX_OUT=0 and Busy=1. There is no latency cycle.
- Bit timing: a period counter runs from 0 to Prescale-1 within each bit. The state advances on the edge where the count equals Prescale-1, and the count then wraps to 0.
- START: TX_OUT=0 for one bit period, then DATA.
- DATA: TX_OUT = shadow data bit[bit_cnt]. bit_cnt counts 0..DATA_WIDTH-1, LSB first. After the last bit period the state goes to PARITY if the latched PAR_EN=1, otherwise to STOP.
- PARITY: TX_OUT = XOR-reduce(shadow data) when PAR_TYP=0, XNOR-reduce when PAR_TYP=1. Parity is computed from the latched data only. One bit period, then STOP.
- STOP: TX_OUT=1 for one bit period, then IDLE. Busy falls on the same edge that enters IDLE.
- Busy stays high for exactly (2 + DATA_WIDTH + PAR_EN) × Prescale cycles per frame.
- Data_Valid is ignored in every state except IDLE. Changes to P_DATA, PAR_EN, PAR_TYP or Prescale during a frame do not affect it.
- Back-to-back: if Data_Valid is held high, the next frame is accepted in the first IDLE cycle. Frames are therefore separated by exactly 1 cycle of TX_OUT=1.
- Unused or illegal state encodings return to IDLE on the next edge with TX_OUT=1 and Busy=0.
- TX_OUT and Busy come straight from flops, with no combinational path from the inputs.

Test Plan:
1. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, Prescale=1, one-cycle Data_Valid -> TX_OUT is 0,1,0,1,0,0,1,0,1,0,1 on consecutive cycles (even parity bit = 0); Busy high for exactly 11 cycles; then TX_OUT=1, Busy=0.
2. P_DATA=8'h01, PAR_EN=1, PAR_TYP=1, Prescale=4 -> each bit held 4 cycles: start 0, data 1 then seven 0s, odd parity bit 0, stop 1; Busy high for 44 cycles.
3. P_DATA=8'hFF, PAR_EN=0, Prescale=2 -> TX_OUT low for 2 cycles, then high for 18 cycles; Busy high for 20 cycles; no parity slot.
4. Start 8'h3C (PAR_EN=0, Prescale=1). Mid-frame, pulse Data_Valid with P_DATA=8'hC3 and toggle PAR_EN -> transmitted bits are those of 8'h3C only (0,0,0,1,1,1,1,0,0,1); the second request is dropped.
5. Assert RST=0 for one cycle during the DATA state of an 8'h55 frame -> after that edge TX_OUT=1 and Busy=0; the next Data_Valid starts a complete fresh frame.
6. Data_Valid held high with P_DATA=8'h0F, PAR_EN=0, Prescale=1 -> frames repeat with a period of 11 cycles: 10-cycle frame plus 1 idle cycle with TX_OUT=1 and Busy=0.

Source files
------------

// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Each bit lasts Prescale clocks; TX_OUT and Busy are driven directly from flops.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic                  tx_reg, tx_next;
    logic                  busy_reg, busy_next;
    logic [5:0]            period_cnt_reg, period_cnt_next;
    logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0] data_reg;
    logic                  par_en_reg;
    logic                  par_typ_reg;
    logic [5:0]            prescale_reg;

    logic                  accept;
    logic                  period_last;
    logic                  parity_bit;
    logic [BIT_W-1:0]      bit_inc;

    assign accept      = (state_reg == IDLE) && Data_Valid;
    assign period_last = (period_cnt_reg == prescale_reg - 6'd1);
    // Odd parity is the complement of even parity.
    assign parity_bit  = (^data_reg) ^ par_typ_reg;
    assign bit_inc     = bit_cnt_reg + BIT_W'(1);

    always_comb begin
        state_next      = state_reg;
        tx_next         = tx_reg;
        busy_next       = busy_reg;
        bit_cnt_next    = bit_cnt_reg;
        period_cnt_next = period_last ? 6'd0 : period_cnt_reg + 6'd1;

        case (state_reg)
            IDLE: begin
                tx_next         = 1'b1;
                busy_next       = 1'b0;
                period_cnt_next = 6'd0;
                bit_cnt_next    = '0;
                if (Data_Valid) begin
                    state_next = START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            START: begin
                if (period_last) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = data_reg[0];
                end
            end
            DATA: begin
                if (period_last) begin
                    if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
                        if (par_en_reg) begin
                            state_next = PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_cnt_next = bit_inc;
                        tx_next      = data_reg[bit_inc];
                    end
                end
            end
            PARITY: begin
                if (period_last) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (period_last) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next      = IDLE;
                tx_next         = 1'b1;
                busy_next       = 1'b0;
                period_cnt_next = 6'd0;
                bit_cnt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg      <= IDLE;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            period_cnt_reg <= 6'd0;
            bit_cnt_reg    <= '0;
            data_reg       <= '0;
            par_en_reg     <= 1'b0;
            par_typ_reg    <= 1'b0;
            prescale_reg   <= 6'd0;
        end else begin
            state_reg      <= state_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            period_cnt_reg <= period_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            // Frame settings are frozen at acceptance so mid-frame input changes are harmless.
            if (accept) begin
                data_reg     <= P_DATA;
                par_en_reg   <= PAR_EN;
                par_typ_reg  <= PAR_TYP;
                prescale_reg <= (Prescale == 6'd0) ? 6'd1 : Prescale;
            end
        end
    end

    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frames, randomized frames, mid-frame
// request and reset handling, and back-to-back frames, against a frame-level model.
module tb_uart_tx_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [5:0] prescale = 6'd1;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .P_DATA     (p_data),
        .Data_Valid (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .Prescale   (prescale),
        .TX_OUT     (tx_out),
        .Busy       (busy)
    );

    always #5 clk = ~clk;

    // Expected line level k cycles after the accepting edge (k=0 is the first start-bit cycle).
    function automatic logic model_tx(logic [7:0] d, logic pen, logic ptyp, int p, int k);
        int ep;
        int slot;
        ep   = (p == 0) ? 1 : p;
        slot = k / ep;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (pen && slot == 9) return (^d) ^ ptyp;
        return 1'b1;
    endfunction

    function automatic int model_len(logic pen, int p);
        return ((p == 0) ? 1 : p) * (10 + (pen ? 1 : 0));
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx got %b expected 1", tx_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b expected 0", busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
        end
        $display("reset: tx=%b busy=%b", tx_out, busy);
    endtask

    task automatic test_directed();
        logic [7:0] d_tab [3] = '{8'hA5, 8'h01, 8'hFF};
        logic       e_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic       t_tab [3] = '{1'b0, 1'b1, 1'b0};
        int         p_tab [3] = '{1, 4, 2};
        for (int i = 0; i < 3; i++) begin
            int len;
            int bad;
            logic exp_tx;
            len = model_len(e_tab[i], p_tab[i]);
            bad = errors;
            p_data = d_tab[i]; par_en = e_tab[i]; par_typ = t_tab[i];
            prescale = 6'(p_tab[i]);
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            for (int k = 0; k <= len; k++) begin
                if (k > 0) @(negedge clk);
                exp_tx = model_tx(d_tab[i], e_tab[i], t_tab[i], p_tab[i], k);
                checks++;
                if (tx_out !== exp_tx) begin
                    errors++;
                    $display("FAIL directed%0d_tx cycle %0d got %b expected %b", i, k, tx_out, exp_tx);
                end
                checks++;
                if (busy !== (k < len)) begin
                    errors++;
                    $display("FAIL directed%0d_busy cycle %0d got %b expected %b", i, k, busy, (k < len));
                end
            end
            $display("directed frame data=%h pen=%b ptyp=%b presc=%0d len=%0d errs=%0d",
                     d_tab[i], e_tab[i], t_tab[i], p_tab[i], len, errors - bad);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [7:0] d;
            logic pen, ptyp, exp_tx;
            int p, len, bad;
            d = 8'($urandom); pen = 1'($urandom); ptyp = 1'($urandom);
            p = $urandom_range(0, 5);
            len = model_len(pen, p);
            bad = errors;
            p_data = d; par_en = pen; par_typ = ptyp; prescale = 6'(p);
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
            for (int k = 0; k <= len; k++) begin
                if (k > 0) @(negedge clk);
                exp_tx = model_tx(d, pen, ptyp, p, k);
                checks++;
                if (tx_out !== exp_tx) begin
                    errors++;
                    $display("FAIL random%0d_tx cycle %0d got %b expected %b", i, k, tx_out, exp_tx);
                end
                checks++;
                if (busy !== (k < len)) begin
                    errors++;
                    $display("FAIL random%0d_busy cycle %0d got %b expected %b", i, k, busy, (k < len));
                end
                // Scramble the inputs mid-frame; the latched copy must be what goes out.
                if (k < len) begin
                    p_data = 8'($urandom); par_en = 1'($urandom);
                    par_typ = 1'($urandom); prescale = 6'($urandom);
                end
            end
            $display("random frame %0d data=%h pen=%b ptyp=%b presc=%0d errs=%0d",
                     i, d, pen, ptyp, p, errors - bad);
        end
    endtask

    task automatic test_ignore_midframe();
        int len, bad;
        logic exp_tx;
        len = model_len(1'b0, 1);
        bad = errors;
        p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k <= len + 2; k++) begin
            if (k > 0) @(negedge clk);
            exp_tx = model_tx(8'h3C, 1'b0, 1'b0, 1, k);
            checks++;
            if (tx_out !== exp_tx) begin
                errors++;
                $display("FAIL ignore_tx cycle %0d got %b expected %b", k, tx_out, exp_tx);
            end
            checks++;
            if (busy !== (k < len)) begin
                errors++;
                $display("FAIL ignore_busy cycle %0d got %b expected %b", k, busy, (k < len));
            end
            if (k == 3) begin
                data_valid = 1'b1; p_data = 8'hC3; par_en = 1'b1;
            end
            if (k == 4) begin
                data_valid = 1'b0; par_en = 1'b0;
            end
        end
        $display("midframe request dropped: data=3C errs=%0d", errors - bad);
    endtask

    task automatic test_reset_midframe();
        int len, bad;
        logic exp_tx;
        len = model_len(1'b0, 2);
        bad = errors;
        p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd2;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            exp_tx = model_tx(8'h55, 1'b0, 1'b0, 2, k);
            checks++;
            if (tx_out !== exp_tx || busy !== 1'b1) begin
                errors++;
                $display("FAIL prereset cycle %0d got tx=%b busy=%b expected tx=%b busy=1", k, tx_out, busy, exp_tx);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset got tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
        end
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
        end
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            if (k > 0) @(negedge clk);
            exp_tx = model_tx(8'h55, 1'b0, 1'b0, 2, k);
            checks++;
            if (tx_out !== exp_tx || busy !== (k < len)) begin
                errors++;
                $display("FAIL fresh_frame cycle %0d got tx=%b busy=%b expected tx=%b busy=%b",
                         k, tx_out, busy, exp_tx, (k < len));
            end
        end
        $display("reset mid-frame then fresh frame data=55 errs=%0d", errors - bad);
    endtask

    task automatic test_back_to_back();
        int bad, m;
        logic exp_tx, exp_busy;
        bad = errors;
        p_data = 8'h0F; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd1;
        data_valid = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 33; k++) begin
            if (k > 0) @(negedge clk);
            m = k % 11;
            exp_tx   = (m < 10) ? model_tx(8'h0F, 1'b0, 1'b0, 1, m) : 1'b1;
            exp_busy = (m < 10);
            checks++;
            if (tx_out !== exp_tx) begin
                errors++;
                $display("FAIL b2b_tx cycle %0d got %b expected %b", k, tx_out, exp_tx);
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL b2b_busy cycle %0d got %b expected %b", k, busy, exp_busy);
            end
        end
        data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stop got tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
        end
        $display("back-to-back 3 frames data=0F errs=%0d", errors - bad);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_midframe();
        test_reset_midframe();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
